flash_audio_feeder: RTL
=======================

// Module: flash_audio_feeder
// PURPOSE
//  Upstream stage of the LED level meter. Fetches 32-bit words from flash, splits each word into two
//  16-bit signed PCM samples and presents the upper byte as an 8-bit sample on audio.
//  Each sample is paced by sample_tick and marked by a 1-cycle read_sig strobe for the meter
//  (Light_Control). Supports play/pause, forward/reverse and restart.
// PARAMETERS
//  ADDR_W     23          flash word-address width
//  START_ADDR 23'h000000  first word of the clip
//  END_ADDR   23'h07FFFF  last word of the clip (inclusive), > START_ADDR
// PORTS
//  clk                  in   1       system clock (50 MHz)
//  reset_n              in   1       async active-low reset
//  sample_tick          in   1       1-cycle pulse at sample rate (e.g. 22 kHz), from rate divider
//  play                 in   1       1 = run, 0 = pause (level)
//  dir                  in   1       0 = forward, 1 = reverse (level)
//  restart              in   1       1-cycle pulse: jump to clip start (fwd) / end (rev)
//  flash_read           out  1       Avalon read request
//  flash_address        out  ADDR_W  word address
//  flash_waitrequest    in   1       slave stall
//  flash_readdatavalid  in   1       read data valid
//  flash_readdata       in   32      read data
//  audio                out  8       current sample, signed (sample[15:8])
//  read_sig             out  1       1-cycle strobe: new value on audio
//  underrun             out  1       sticky: a tick was lost
// BEHAVIOUR
//  Reset (async, any state):
//   - flash_read=0, flash_address=START_ADDR, audio=0, read_sig=0, underrun=0, state=IDLE.
//   - Pending tick and pending restart are cleared.
//   - An in-flight flash read is abandoned; a late readdatavalid after reset is ignored.
//  FSM states: IDLE, REQ, WAIT_DATA, EMIT0, EMIT1, ADVANCE.
//   - IDLE -> REQ when play=1.
//   - REQ: flash_read=1; hold address and read until a cycle with flash_waitrequest=0 -> WAIT_DATA.
//   - WAIT_DATA: capture flash_readdata on flash_readdatavalid -> EMIT0.
//   - EMIT0: on (tick or pending tick) and play=1, emit first half -> EMIT1.
//   - EMIT1: same condition, emit second half -> ADVANCE.
//   - ADVANCE (1 cycle): update address -> REQ if play=1, else IDLE.
//  Half order is fixed at capture (dir sampled in WAIT_DATA):
//   - fwd: [15:0] then [31:16].
//   - rev: [31:16] then [15:0].
//  Emit: audio <= half[15:8] and read_sig <= 1 on the same edge; read_sig is high exactly 1 cycle.
//   - audio holds until the next emit (the consumer needs >=3 stable cycles; guaranteed by tick spacing).
//  Address update in ADVANCE (dir sampled here, so a dir change takes effect at the word boundary):
//   - restart pending: load START_ADDR (fwd) / END_ADDR (rev), then clear pending.
//   - fwd: addr==END_ADDR ? START_ADDR : addr+1.
//   - rev: addr==START_ADDR ? END_ADDR : addr-1.
//  restart in IDLE: address reloads immediately.
//  Simultaneous restart and ADVANCE: restart wins; the address is reloaded that cycle.
//  Tick handling: a tick outside EMIT0/EMIT1, or while play=0, is held in a 1-deep pending bit.
//   - Pending is consumed on the next eligible emit.
//   - A tick while pending=1 is dropped and sets underrun (cleared only by reset).
//   - Tick and pending together in EMITx: one emit, pending stays 1.
//  Pause: play=0 never aborts a flash transaction.
//   - REQ/WAIT_DATA complete; EMIT states hold; ADVANCE goes to IDLE.
//  Latency: read_sig rises on the clk edge after the eligible tick.
// STRUCTURE
//  audio_pkg:
//   - typedef enum logic [2:0] feeder_state_t.
//   - FLASH_ADDR_W, CLIP_START, CLIP_END constants; shared with the rate divider and the top level.
//  Sub-module flash_word_reader: Avalon single-word read (start, addr -> data, done).
//   - Owns flash_read/waitrequest/readdatavalid and the abandon-on-reset rule.
//  Parent: FSM, half select, address counter, tick/restart pending logic.
// TESTING
//  1. fwd, word 0x1234ABCD at START_ADDR, two ticks -> audio=0xAB then 0x12, each with one read_sig cycle.
//  2. rev, same word -> audio=0x12 then 0xAB.
//     Next flash_address = END_ADDR (wrap from START_ADDR).
//  3. waitrequest high 5 cycles in REQ -> flash_read and flash_address stable all 5 cycles.
//     One read only; no read_sig before readdatavalid.
//  4. Two ticks during a 40-cycle readdatavalid delay -> one emit at capture, underrun=1.
//     Subsequent emits still correct.
//  5. restart mid-word (fwd, addr=START+7) -> remaining half emitted, next address = START_ADDR.
//  6. reset_n low during WAIT_DATA, then stray readdatavalid -> all outputs at reset values.
//     No read_sig; after release with play=1, first read at START_ADDR.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared clip constants and feeder FSM encoding for the audio level-meter path
package audio_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam logic [FLASH_ADDR_W-1:0] CLIP_START = 23'h000000;
    localparam logic [FLASH_ADDR_W-1:0] CLIP_END   = 23'h07FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_EMIT0,
        ST_EMIT1,
        ST_ADVANCE
    } feeder_state_t;

endpackage

// File: rtl/flash_word_reader.sv
// rtl/flash_word_reader.sv - Avalon single-word read: holds read until accepted, then waits for data
module flash_word_reader
    import audio_pkg::*;
#(
    parameter int ADDR_W = FLASH_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    output logic              accepted,
    output logic [31:0]       data,
    output logic              done,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [31:0]       flash_readdata
);

    // Only a read accepted since the last reset may complete; reset drops the
    // outstanding flag so a late readdatavalid is ignored.
    logic waiting;

    assign flash_read    = start;
    assign flash_address = addr;
    assign accepted      = start & ~flash_waitrequest;
    assign done          = waiting & flash_readdatavalid;
    assign data          = flash_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waiting <= 1'b0;
        end else if (accepted) begin
            waiting <= 1'b1;
        end else if (flash_readdatavalid) begin
            waiting <= 1'b0;
        end
    end

endmodule

// File: rtl/flash_audio_feeder.sv
// rtl/flash_audio_feeder.sv - fetches 32-bit flash words and emits 8-bit samples paced by sample_tick
module flash_audio_feeder
    import audio_pkg::*;
#(
    parameter int                ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = CLIP_START,
    parameter logic [ADDR_W-1:0] END_ADDR   = CLIP_END
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              play,
    input  logic              dir,
    input  logic              restart,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [31:0]       flash_readdata,
    output logic [7:0]        audio,
    output logic              read_sig,
    output logic              underrun
);

    feeder_state_t     state, state_next;
    logic [ADDR_W-1:0] addr, addr_step, addr_reload;
    logic [31:0]       word_q;
    logic [31:0]       rd_data;
    logic              rd_accepted, rd_done;
    logic              tick_pend, restart_pend;
    logic              emit;

    flash_word_reader #(.ADDR_W(ADDR_W)) u_reader (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (state == ST_REQ),
        .addr                (addr),
        .accepted            (rd_accepted),
        .data                (rd_data),
        .done                (rd_done),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata)
    );

    assign emit = ((state == ST_EMIT0) || (state == ST_EMIT1)) && play && (sample_tick || tick_pend);

    always_comb begin
        addr_reload = dir ? END_ADDR : START_ADDR;
        addr_step   = addr;
        if (dir) begin
            addr_step = (addr == START_ADDR) ? END_ADDR : addr - 1'b1;
        end else begin
            addr_step = (addr == END_ADDR) ? START_ADDR : addr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (play) state_next = ST_REQ;
            ST_REQ:       if (rd_accepted) state_next = ST_WAIT_DATA;
            ST_WAIT_DATA: if (rd_done) state_next = ST_EMIT0;
            ST_EMIT0:     if (emit) state_next = ST_EMIT1;
            ST_EMIT1:     if (emit) state_next = ST_ADVANCE;
            ST_ADVANCE:   state_next = play ? ST_REQ : ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= START_ADDR;
            word_q       <= '0;
            audio        <= '0;
            read_sig     <= 1'b0;
            underrun     <= 1'b0;
            tick_pend    <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            read_sig <= emit;
            if (emit) begin
                audio <= (state == ST_EMIT0) ? word_q[15:8] : word_q[31:24];
            end
            // Store halves in emit order so EMIT0 always reads the low half.
            if ((state == ST_WAIT_DATA) && rd_done) begin
                word_q <= dir ? {rd_data[15:0], rd_data[31:16]} : rd_data;
            end
            if (emit) begin
                tick_pend <= sample_tick & tick_pend;
            end else if (sample_tick) begin
                if (tick_pend) begin
                    underrun <= 1'b1;
                end
                tick_pend <= 1'b1;
            end
            if ((state == ST_IDLE) && restart) begin
                addr <= addr_reload;
            end else if (state == ST_ADVANCE) begin
                addr         <= (restart || restart_pend) ? addr_reload : addr_step;
                restart_pend <= 1'b0;
            end else if (restart) begin
                restart_pend <= 1'b1;
            end
        end
    end

endmodule
